// File: rtl/lap_timer_pkg.sv
// Shared types for the lap timer: FSM state encoding and full-buffer policy codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lap_timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE
  } state_t;

  // Full-buffer policy: drop the incoming lap, or overwrite the oldest one.
  localparam int WRAP_DROP      = 0;
  localparam int WRAP_OVERWRITE = 1;

endpackage

// File: rtl/lap_timer_mem_if.sv
// Front-panel command, status and lap readout bundle of the lap timer.
// Latency: n/a (wiring only).
// Backpressure: none; commands are level-sampled, reads are accepted every cycle.
interface lap_timer_mem_if #(
  parameter int CNT_W = 8,
  parameter int AW    = 4
);
  // command side
  logic             start;
  logic             pause;
  logic             stop;
  logic             lap;
  logic             clear;
  // status side
  logic             tick;
  logic [CNT_W-1:0] unit_count;
  logic [1:0]       state;
  // lap readout
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic [AW:0]      lap_count;
  logic             lap_full;
  logic             lap_overflow;

  modport master (
    output start, pause, stop, lap, clear, rd_en, rd_addr,
    input  tick, unit_count, state, rd_data, rd_valid,
    input  lap_count, lap_full, lap_overflow
  );

  modport slave (
    input  start, pause, stop, lap, clear, rd_en, rd_addr,
    output tick, unit_count, state, rd_data, rd_valid,
    output lap_count, lap_full, lap_overflow
  );

endinterface

// File: rtl/lap_timer_mem_ram.sv
// Lap storage: synchronous write port, registered read port returning old data on same-address collision.
// Latency: 1 cycle read; write visible to a read issued the following cycle.
// Backpressure: none; one read and one write accepted every cycle.
module lap_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Array write; contents are never reset, the owner hides stale entries.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register: old contents on collision, zero when the read is not qualified.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
    else           r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lap_timer_mem.sv
// Stopwatch: prescaled unit counter gated by an IDLE/RUN/PAUSE FSM, laps captured into a ring buffer.
// Latency: commands act at the next edge; lap readout has 1-cycle latency.
// Backpressure: none; a lap into a full buffer is dropped or overwrites the oldest per WRAP_MODE.
module lap_timer_mem
  import lap_timer_pkg::*;
#(
  parameter int DIV       = 50_000_000,
  parameter int CNT_W     = 8,
  parameter int LAP_DEPTH = 16,
  parameter int WRAP_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  lap_timer_mem_if.slave bus
);

  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam bit OVERWRITE = (WRAP_MODE != WRAP_DROP);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_presc;
  logic [CNT_W-1:0]  r_unit;
  logic              r_tick;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_base_ptr;
  logic [CW-1:0]     r_lap_count;
  logic              r_lap_full;
  logic              r_overflow;
  logic              r_rd_valid;

  logic [AW-1:0]     w_wr_ptr_nxt;
  logic [AW-1:0]     w_base_ptr_nxt;
  logic [CW-1:0]     w_lap_count_nxt;
  logic              w_overflow_nxt;

  logic              w_presc_wrap;
  logic              w_enter_run;
  logic              w_idle_clear;
  logic              w_lap_act;
  logic              w_full;
  logic              w_wr_en;
  logic              w_rd_hit;
  logic [AW-1:0]     w_rd_phys;
  logic [CNT_W-1:0]  w_ram_rdata;

  assign w_presc_wrap = (r_state == RUN) && (r_presc == PW'(DIV - 1));
  assign w_enter_run  = (r_state == IDLE) && (w_state_nxt == RUN);
  assign w_idle_clear = (r_state == IDLE) && bus.clear;
  // Lap capture follows the registered state, not the transition requested this cycle.
  assign w_lap_act    = bus.lap && (r_state != IDLE);
  assign w_full       = (r_lap_count == CW'(LAP_DEPTH));
  assign w_wr_en      = w_lap_act && (!w_full || OVERWRITE);
  // Valid decision uses the pre-update count so a same-cycle lap is not yet visible.
  assign w_rd_hit     = bus.rd_en && ({1'b0, bus.rd_addr} < r_lap_count);
  assign w_rd_phys    = r_base_ptr + bus.rd_addr;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state with stop > pause > start priority.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!bus.stop && !bus.pause && bus.start) w_state_nxt = RUN;
      end
      RUN: begin
        if (bus.stop)       w_state_nxt = IDLE;
        else if (bus.pause) w_state_nxt = PAUSE;
      end
      PAUSE: begin
        if (bus.stop)                       w_state_nxt = IDLE;
        else if (bus.start && !bus.pause)   w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Prescaler and unit counter: restart on entry to RUN, advance only while RUN, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_unit  <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_enter_run) begin
        r_presc <= '0;
        r_unit  <= '0;
      end else if (w_idle_clear) begin
        r_unit  <= '0;
      end else if (r_state == RUN) begin
        if (w_presc_wrap) begin
          r_presc <= '0;
          r_unit  <= r_unit + CNT_W'(1);
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  // Ring-buffer bookkeeping: clear in IDLE, append, drop or overwrite-oldest when full.
  always_comb begin
    w_wr_ptr_nxt    = r_wr_ptr;
    w_base_ptr_nxt  = r_base_ptr;
    w_lap_count_nxt = r_lap_count;
    w_overflow_nxt  = r_overflow;
    if (w_idle_clear) begin
      w_wr_ptr_nxt    = '0;
      w_base_ptr_nxt  = '0;
      w_lap_count_nxt = '0;
      w_overflow_nxt  = 1'b0;
    end else if (w_lap_act) begin
      if (!w_full) begin
        w_wr_ptr_nxt    = r_wr_ptr + AW'(1);
        w_lap_count_nxt = r_lap_count + CW'(1);
      end else begin
        w_overflow_nxt = 1'b1;
        if (OVERWRITE) begin
          w_wr_ptr_nxt   = r_wr_ptr + AW'(1);
          w_base_ptr_nxt = r_base_ptr + AW'(1);
        end
      end
    end
  end

  // Buffer pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_base_ptr  <= '0;
      r_lap_count <= '0;
      r_lap_full  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_base_ptr  <= w_base_ptr_nxt;
      r_lap_count <= w_lap_count_nxt;
      r_lap_full  <= (w_lap_count_nxt == CW'(LAP_DEPTH));
      r_overflow  <= w_overflow_nxt;
    end
  end

  // Read-valid register, aligned with the RAM read register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_valid <= 1'b0;
    else      r_rd_valid <= w_rd_hit;
  end

  lap_ram #(
    .DEPTH (LAP_DEPTH),
    .WIDTH (CNT_W)
  ) u_lap_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_unit),
    .i_re    (w_rd_hit),
    .i_raddr (w_rd_phys),
    .o_rdata (w_ram_rdata)
  );

  assign bus.tick         = r_tick;
  assign bus.unit_count   = r_unit;
  assign bus.state        = r_state;
  assign bus.rd_data      = w_ram_rdata;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.lap_count    = r_lap_count;
  assign bus.lap_full     = r_lap_full;
  assign bus.lap_overflow = r_overflow;

endmodule

// File: tb/tb_lap_timer_mem.sv
// Bench for lap_timer_mem: one drop-mode and one overwrite-mode instance driven with identical commands.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_lap_timer_mem;
  import lap_timer_pkg::*;

  localparam int DIV   = 4;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start, pause, stop, lap, clear, rd_en;
  logic [AW-1:0] rd_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lap_timer_mem_if #(.CNT_W(CNT_W), .AW(AW)) if_drop ();
  lap_timer_mem_if #(.CNT_W(CNT_W), .AW(AW)) if_wrap ();

  assign if_drop.start = start;   assign if_wrap.start = start;
  assign if_drop.pause = pause;   assign if_wrap.pause = pause;
  assign if_drop.stop  = stop;    assign if_wrap.stop  = stop;
  assign if_drop.lap   = lap;     assign if_wrap.lap   = lap;
  assign if_drop.clear = clear;   assign if_wrap.clear = clear;
  assign if_drop.rd_en = rd_en;   assign if_wrap.rd_en = rd_en;
  assign if_drop.rd_addr = rd_addr;
  assign if_wrap.rd_addr = rd_addr;

  lap_timer_mem #(.DIV(DIV), .CNT_W(CNT_W), .LAP_DEPTH(DEPTH), .WRAP_MODE(WRAP_DROP)) u_drop (
    .clk (clk), .rst (rst), .bus (if_drop)
  );

  lap_timer_mem #(.DIV(DIV), .CNT_W(CNT_W), .LAP_DEPTH(DEPTH), .WRAP_MODE(WRAP_OVERWRITE)) u_wrap (
    .clk (clk), .rst (rst), .bus (if_wrap)
  );

  typedef struct {
    logic start;
    logic pause;
    logic stop;
    int   reps;
    int   st;
    int   unit;
    int   tick;
  } vec_t;

  typedef struct {
    int addr;
    int drop_d;
    int wrap_d;
  } rvec_t;

  vec_t  va [26];
  rvec_t rv [4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmds_off();
    start = 1'b0; pause = 1'b0; stop = 1'b0; lap = 1'b0; clear = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (if_drop.tick) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},   int'(if_drop.state),        0);
    chk({tag, "_unit"},    int'(if_drop.unit_count),   0);
    chk({tag, "_tick"},    int'(if_drop.tick),         0);
    chk({tag, "_rdata"},   int'(if_drop.rd_data),      0);
    chk({tag, "_rvalid"},  int'(if_drop.rd_valid),     0);
    chk({tag, "_lapcnt"},  int'(if_drop.lap_count),    0);
    chk({tag, "_full"},    int'(if_drop.lap_full),     0);
    chk({tag, "_ovf"},     int'(if_drop.lap_overflow), 0);
    chk({tag, "_w_state"}, int'(if_wrap.state),        0);
    chk({tag, "_w_rdata"}, int'(if_wrap.rd_data),      0);
    chk({tag, "_w_rvalid"},int'(if_wrap.rd_valid),     0);
    chk({tag, "_w_lapcnt"},int'(if_wrap.lap_count),    0);
  endtask

  initial begin
    // {start, pause, stop, cycles, state after, unit_count after, tick after}
    va[0]  = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0};
    va[1]  = '{1'b0, 1'b0, 1'b0, 3, 1, 0, 0};
    va[2]  = '{1'b0, 1'b0, 1'b0, 1, 1, 1, 1};
    va[3]  = '{1'b0, 1'b0, 1'b0, 3, 1, 1, 0};
    va[4]  = '{1'b0, 1'b0, 1'b0, 1, 1, 2, 1};
    va[5]  = '{1'b0, 1'b0, 1'b0, 3, 1, 2, 0};
    va[6]  = '{1'b0, 1'b0, 1'b0, 1, 1, 3, 1};
    va[7]  = '{1'b0, 1'b0, 1'b0, 2, 1, 3, 0};
    va[8]  = '{1'b0, 1'b1, 1'b0, 1, 2, 3, 0};
    va[9]  = '{1'b0, 1'b1, 1'b0, 4, 2, 3, 0};
    va[10] = '{1'b1, 1'b0, 1'b0, 1, 1, 3, 0};
    va[11] = '{1'b0, 1'b0, 1'b0, 1, 1, 4, 1};
    va[12] = '{1'b1, 1'b0, 1'b1, 1, 0, 4, 0};
    va[13] = '{1'b0, 1'b0, 1'b0, 2, 0, 4, 0};
    va[14] = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0};
    va[15] = '{1'b0, 1'b0, 1'b0, 3, 1, 0, 0};
    va[16] = '{1'b0, 1'b0, 1'b0, 1, 1, 1, 1};
    va[17] = '{1'b0, 1'b0, 1'b0, 3, 1, 1, 0};
    va[18] = '{1'b0, 1'b0, 1'b0, 1, 1, 2, 1};
    va[19] = '{1'b0, 1'b0, 1'b0, 2, 1, 2, 0};
    va[20] = '{1'b0, 1'b1, 1'b0, 1, 2, 2, 0};
    va[21] = '{1'b0, 1'b1, 1'b0, 4, 2, 2, 0};
    va[22] = '{1'b1, 1'b0, 1'b0, 1, 1, 2, 0};
    va[23] = '{1'b0, 1'b0, 1'b0, 1, 1, 3, 1};
    va[24] = '{1'b1, 1'b1, 1'b0, 1, 2, 3, 0};
    va[25] = '{1'b0, 1'b0, 1'b1, 1, 0, 3, 0};

    // laps taken at counts 1..5 into a 4-deep buffer
    rv[0] = '{0, 1, 2};
    rv[1] = '{1, 2, 3};
    rv[2] = '{2, 3, 4};
    rv[3] = '{3, 4, 5};

    cmds_off();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    #2 rst = 1'b1;

    // run, tick cadence, pause/resume, command priority
    for (int i = 0; i < 26; i++) begin
      start = va[i].start;
      pause = va[i].pause;
      stop  = va[i].stop;
      for (int r = 0; r < va[i].reps; r++) step();
      cmds_off();
      chk($sformatf("run%0d_state", i), int'(if_drop.state),      va[i].st);
      chk($sformatf("run%0d_unit", i),  int'(if_drop.unit_count), va[i].unit);
      chk($sformatf("run%0d_tick", i),  int'(if_drop.tick),       va[i].tick);
    end

    // laps at counts 1..5; the fifth collides with a read of the oldest entry
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_tick($sformatf("lap%0d_tickwait", k));
      chk($sformatf("lap%0d_unit", k), int'(if_drop.unit_count), k);
      lap = 1'b1;
      if (k == 5) begin
        rd_en = 1'b1;
        rd_addr = 2'd0;
      end
      step();
      cmds_off();
      chk($sformatf("lap%0d_cnt", k), int'(if_drop.lap_count), (k < 4) ? k : 4);
      if (k == 4) begin
        chk("lap4_full", int'(if_drop.lap_full),     1);
        chk("lap4_ovf",  int'(if_drop.lap_overflow), 0);
      end
    end
    chk("drop_full",   int'(if_drop.lap_full),     1);
    chk("drop_ovf",    int'(if_drop.lap_overflow), 1);
    chk("wrap_cnt",    int'(if_wrap.lap_count),    4);
    chk("wrap_ovf",    int'(if_wrap.lap_overflow), 1);
    chk("rbw_drop_d",  int'(if_drop.rd_data),      1);
    chk("rbw_wrap_d",  int'(if_wrap.rd_data),      1);
    chk("rbw_wrap_v",  int'(if_wrap.rd_valid),     1);

    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_state", int'(if_drop.state), 0);

    // back-to-back readback of both policies
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      rd_addr = AW'(rv[i].addr);
      step();
      chk($sformatf("rd%0d_drop_d", i), int'(if_drop.rd_data),  rv[i].drop_d);
      chk($sformatf("rd%0d_drop_v", i), int'(if_drop.rd_valid), 1);
      chk($sformatf("rd%0d_wrap_d", i), int'(if_wrap.rd_data),  rv[i].wrap_d);
      chk($sformatf("rd%0d_wrap_v", i), int'(if_wrap.rd_valid), 1);
    end
    cmds_off();
    step();
    chk("noread_valid", int'(if_drop.rd_valid), 0);

    // lap in IDLE must not touch the buffer
    lap = 1'b1; step(); lap = 1'b0;
    rd_en = 1'b1; rd_addr = 2'd0; step(); cmds_off();
    chk("idlelap_cnt",   int'(if_drop.lap_count), 4);
    chk("idlelap_wrapd", int'(if_wrap.rd_data),   2);

    // clear in IDLE
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_cnt",  int'(if_drop.lap_count),    0);
    chk("clear_full", int'(if_drop.lap_full),     0);
    chk("clear_ovf",  int'(if_drop.lap_overflow), 0);
    chk("clear_unit", int'(if_drop.unit_count),   0);
    chk("clear_wovf", int'(if_wrap.lap_overflow), 0);
    rd_en = 1'b1; rd_addr = 2'd0; step(); cmds_off();
    chk("clear_rd_v", int'(if_drop.rd_valid), 0);
    chk("clear_rd_d", int'(if_drop.rd_data),  0);

    // counter wrap 0xFF -> 0x00
    start = 1'b1; step(); start = 1'b0;
    repeat (1020) step();
    chk("ff_unit", int'(if_drop.unit_count), 255);
    chk("ff_tick", int'(if_drop.tick),       1);
    repeat (4) step();
    chk("wrap0_unit", int'(if_drop.unit_count), 0);
    chk("wrap0_tick", int'(if_drop.tick),       1);

    // two laps, immediate readback, out-of-range read
    wait_tick("l2a_tickwait");
    lap = 1'b1; step(); lap = 1'b0;
    wait_tick("l2b_tickwait");
    lap = 1'b1; step(); lap = 1'b0;
    chk("l2_cnt", int'(if_drop.lap_count), 2);
    rd_en = 1'b1; rd_addr = 2'd1; step();
    chk("l2_rd1_d", int'(if_drop.rd_data),  2);
    chk("l2_rd1_v", int'(if_drop.rd_valid), 1);
    rd_addr = 2'd3; step();
    chk("l2_rd3_d", int'(if_drop.rd_data),  0);
    chk("l2_rd3_v", int'(if_drop.rd_valid), 0);
    rd_addr = 2'd0; step();
    chk("l2_rd0_d", int'(if_wrap.rd_data),  1);
    chk("l2_rd0_v", int'(if_wrap.rd_valid), 1);
    cmds_off();

    // asynchronous reset while RUN
    chk("prerst_state", int'(if_drop.state), 1);
    rst = 1'b0;
    #2;
    chk_reset("async");
    step();
    chk_reset("held");
    #2 rst = 1'b1;
    step();
    chk("postrst_state", int'(if_drop.state), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lap_timer_mem.md
# lap_timer_mem

Parametrised stopwatch with lap capture. A prescaler divides `clk` down to a unit tick, and a run/pause/stop state machine gates a unit counter. On each `lap` command the current count is stored in an on-chip lap buffer, which the host reads back by logical index (0 = oldest lap). The block sits between the front-panel command decoder and the display/host readout logic, and supersedes the single-channel fixed-divisor counter with its ad-hoc pause memory.

## Interface
Parameters:
- `DIV`, 50_000_000: `clk` cycles per unit tick; must be ≥ 2.
- `CNT_W`, 8: width of the unit counter and of each lap entry.
- `LAP_DEPTH`, 16: number of lap entries; must be a power of 2, ≥ 2.
- `WRAP_MODE`, 0: full-buffer policy. 0 = drop new laps; 1 = overwrite the oldest lap.

Ports (`AW` = `$clog2(LAP_DEPTH)`):
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled command. Starts counting from IDLE; resumes from PAUSE.
- `pause` in 1: command to freeze counting.
- `stop` in 1: command to return to IDLE.
- `lap` in 1: capture command.
- `clear` in 1: in IDLE, empties the lap buffer and zeroes the count. Ignored in other states.
- `tick` out 1: one-cycle pulse on each unit increment.
- `unit_count` out `CNT_W`: current count.
- `state` out 2: 00 = IDLE, 01 = RUN, 10 = PAUSE.
- `rd_en` in 1: read request.
- `rd_addr` in `AW`: logical lap index.
- `rd_data` out `CNT_W`: read data.
- `rd_valid` out 1: read data valid.
- `lap_count` out `AW+1`: number of stored laps; saturates at `LAP_DEPTH`.
- `lap_full` out 1: `lap_count == LAP_DEPTH`.
- `lap_overflow` out 1: sticky; a lap was dropped or overwrote an older one.

## Operation
- Command priority when several are asserted in one cycle: `stop` > `pause` > `start`.
- IDLE:
  - `start` → RUN. The prescaler and `unit_count` load 0 on entry.
  - `clear` → `unit_count` = 0, `lap_count` = 0, `lap_overflow` = 0.
  - `lap` is ignored.
- RUN:
  - The prescaler counts 0..`DIV`-1.
  - At `DIV`-1 the prescaler wraps to 0, `unit_count` increments modulo 2^`CNT_W`, and `tick` = 1.
  - `pause` → PAUSE; `stop` → IDLE.
- PAUSE:
  - The prescaler and `unit_count` are held.
  - `start` (with `pause` low) → RUN, resuming without clearing.
  - `stop` → IDLE.
- In IDLE, `unit_count` holds its last value for display.
- Lap capture:
  - Acts only when the registered state is RUN or PAUSE, and is independent of any transition requested in the same cycle.
  - The value written is the `unit_count` register as it stands in that cycle, i.e. before any increment at the same edge.
  - Not full: write at `wr_ptr`, then `wr_ptr++` and `lap_count++`.
  - Full, `WRAP_MODE` = 0: the lap is discarded and `lap_overflow` is set.
  - Full, `WRAP_MODE` = 1: overwrite at `wr_ptr`, advance both `wr_ptr` and `base_ptr` (oldest), and set `lap_overflow`.
- Read:
  - Physical address = `base_ptr + rd_addr` (mod `LAP_DEPTH`).
  - If `rd_addr < lap_count`, the entry is returned with `rd_valid` = 1. Otherwise `rd_data` = 0 and `rd_valid` = 0.
  - When a read and a lap write target the same entry in the same cycle, the read returns the old contents (read-before-write). The decision on `rd_valid` uses the pre-update `lap_count`.
- Reset mid-operation: all state is immediately cleared, including buffer pointers. Buffer contents are not reset; they are invisible because `lap_count` = 0.

## Timing
- Reset values: `state` = IDLE; `unit_count` = 0; `tick` = 0; `rd_data` = 0; `rd_valid` = 0; `lap_count` = 0; `lap_full` = 0; `lap_overflow` = 0. The prescaler and all pointers are also 0.
- All outputs are registered.
- Commands take effect at the next rising edge; `state` changes one cycle after the command is sampled.
- `tick` and the incremented `unit_count` become visible at the same edge. The first tick after entering RUN arrives `DIV` cycles after entry.
- Read latency is 1 cycle: `rd_en` at edge N gives `rd_data`/`rd_valid` after edge N. Back-to-back reads are allowed every cycle.
- `rd_valid` is low in any cycle following no `rd_en`.
- Lap capture is visible to a read starting the cycle after the lap is sampled.

## Structure
- Package `lap_timer_pkg`:
  - State enum `IDLE`/`RUN`/`PAUSE` with 2-bit encoding.
  - Localparams `ST_IDLE`, `ST_RUN`, `ST_PAUSE`.
  - The `WRAP_MODE` constants `WRAP_DROP` = 0 and `WRAP_OVERWRITE` = 1.
- Sub-module `lap_ram`:
  - Parameters `DEPTH`, `WIDTH`.
  - Synchronous write port.
  - Registered read port with read-before-write behaviour.
  - No reset on the array.
- The top level holds the FSM, prescaler, unit counter, pointers and read-valid logic.

## Test plan
All scenarios use `DIV` = 4, `CNT_W` = 8, `LAP_DEPTH` = 4.
- Reset, then `start` for 1 cycle → `state` = RUN next cycle; `tick` pulses every 4 cycles; after 12 cycles in RUN, `unit_count` = 3.
- RUN with count 2, `pause` for 5 cycles, then `start` → count stays 2 during PAUSE; the next tick arrives exactly where the prescaler left off.
- Count at 0xFF, tick occurs → `unit_count` = 0x00 with `tick` = 1.
- `WRAP_MODE` = 0: laps at counts 1, 2, 3, 4, 5 → `lap_count` = 4, `lap_full` = 1, `lap_overflow` = 1; reading addresses 0..3 returns 1, 2, 3, 4.
- `WRAP_MODE` = 1, same stimulus → reading addresses 0..3 returns 2, 3, 4, 5; `lap_overflow` = 1.
- Boundary cases:
  - `stop` and `start` asserted together in RUN → IDLE.
  - `rd_en` with `rd_addr` = 3 and `lap_count` = 2 → `rd_valid` = 0, `rd_data` = 0.
  - `clear` in IDLE → `lap_count` = 0 and `lap_overflow` = 0.
  - `rst` pulsed in RUN → all outputs return to their reset values.
